// File: rtl/offnariscv_stage_fifo.sv
// offnariscv_stage_fifo: flushable DEPTH-entry elastic buffer between pipeline stages.
// Rev 1.0 - initial release
`timescale 1ns/1ps
`default_nettype none

module offnariscv_stage_fifo #(
  parameter int TDATA_WIDTH  = 32,
  parameter int DEPTH        = 2,
  parameter bit FALL_THROUGH = 1'b0,
  parameter int CNT_WIDTH    = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  input  logic [TDATA_WIDTH-1:0] s_tdata,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic [TDATA_WIDTH-1:0] m_tdata,
  output logic [CNT_WIDTH-1:0]   count
);

  localparam int PTR_WIDTH = $clog2(DEPTH);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } fill_state_t;

  fill_state_t            state;
  logic [PTR_WIDTH-1:0]   rp;
  logic [PTR_WIDTH-1:0]   wp;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [TDATA_WIDTH-1:0] mem0;
  logic [TDATA_WIDTH-1:0] mem_rest [DEPTH];
  logic                   ft_active;
  logic                   push;
  logic                   pop;
  logic                   wr_en;
  logic                   rd_en;

  always_comb begin
    state = PARTIAL;
    if (cnt == '0)
      state = EMPTY;
    else if (cnt == CNT_WIDTH'(DEPTH))
      state = FULL;
  end

  // Fall-through only bypasses the array while it holds nothing.
  assign ft_active = FALL_THROUGH && (state == EMPTY);

  assign s_tready = (state != FULL) && !flush;

  always_comb begin
    m_tvalid = (state != EMPTY) && !flush;
    m_tdata  = (rp == '0) ? mem0 : mem_rest[rp];
    if (ft_active) begin
      m_tvalid = s_tvalid && !flush;
      m_tdata  = s_tdata;
    end
  end

  assign push = s_tvalid && s_tready;
  assign pop  = m_tvalid && m_tready;

  // A word that falls straight through never touches the array or counter.
  assign wr_en = push && !(ft_active && pop);
  assign rd_en = pop && !ft_active;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rp  <= '0;
      wp  <= '0;
      cnt <= '0;
    end else if (flush) begin
      rp  <= '0;
      wp  <= '0;
      cnt <= '0;
    end else begin
      if (wr_en)
        wp <= wp + PTR_WIDTH'(1);
      if (rd_en)
        rp <= rp + PTR_WIDTH'(1);
      cnt <= cnt + CNT_WIDTH'(wr_en) - CNT_WIDTH'(rd_en);
    end
  end

  // Entry 0 is reset so the registered output reads zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      mem0 <= '0;
    else if (wr_en && (wp == '0))
      mem0 <= s_tdata;
  end

  always_ff @(posedge clk) begin
    if (wr_en && (wp != '0))
      mem_rest[wp] <= s_tdata;
  end

  assign count = cnt;

endmodule

`default_nettype wire

// File: tb/tb_offnariscv_stage_fifo.sv
// tb_offnariscv_stage_fifo: queue-model scoreboard plus directed vectors over three buffer configurations.
// Rev 1.0 - initial release
`timescale 1ns/1ps
`default_nettype none

module tb_offnariscv_stage_fifo;

  localparam int W  = 8;
  localparam int NI = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         s_tvalid = 1'b0;
  logic         m_tready = 1'b0;
  logic [W-1:0] s_tdata = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instance 0: DEPTH 4 registered; 1: DEPTH 2 registered; 2: DEPTH 2 fall-through.
  for (genvar k = 0; k < NI; k++) begin : g_inst
    localparam int D  = (k == 0) ? 4 : 2;
    localparam bit F  = (k == 2);
    localparam int CW = $clog2(D + 1);

    logic          rdy;
    logic          vld;
    logic [W-1:0]  dat;
    logic [CW-1:0] cnt;
    logic [W-1:0]  q[$];

    offnariscv_stage_fifo #(
      .TDATA_WIDTH (W),
      .DEPTH       (D),
      .FALL_THROUGH(F)
    ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush),
      .s_tvalid(s_tvalid),
      .s_tready(rdy),
      .s_tdata (s_tdata),
      .m_tvalid(vld),
      .m_tready(m_tready),
      .m_tdata (dat),
      .count   (cnt)
    );

    always @(posedge rst) q.delete();

    always @(negedge clk) begin : model
      bit           ft;
      bit           e_rdy;
      bit           e_vld;
      bit           push;
      bit           pop;
      logic [W-1:0] e_dat;
      if (!rst) begin
        ft    = F && (q.size() == 0);
        e_rdy = (q.size() < D) && !flush;
        e_vld = ft ? (s_tvalid && !flush) : ((q.size() != 0) && !flush);
        e_dat = ft ? s_tdata : ((q.size() != 0) ? q[0] : '0);
        chk($sformatf("inst%0d s_tready", k), 32'(rdy), 32'(e_rdy));
        chk($sformatf("inst%0d m_tvalid", k), 32'(vld), 32'(e_vld));
        chk($sformatf("inst%0d count", k), 32'(cnt), 32'(q.size()));
        if (e_vld)
          chk($sformatf("inst%0d m_tdata", k), 32'(dat), 32'(e_dat));
        push = s_tvalid && e_rdy;
        pop  = e_vld && m_tready;
        if (flush)
          q.delete();
        else if (!(ft && push && pop)) begin
          if (pop)
            void'(q.pop_front());
          if (push)
            q.push_back(s_tdata);
        end
      end
    end
  end

  typedef struct {
    logic         sv;
    logic [W-1:0] d;
    logic         mr;
    logic         e_rdy;
    logic         e_vld;
    logic [W-1:0] e_dat;
    logic [2:0]   e_cnt;
  } vec_t;

  vec_t tbl[9];

  task automatic drive(input logic sv, input logic [W-1:0] d, input logic mr, input logic fl);
    @(posedge clk);
    #1;
    s_tvalid = sv;
    s_tdata  = d;
    m_tready = mr;
    flush    = fl;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " inst0 count"}, 32'(g_inst[0].cnt), 32'd0);
    chk({tag, " inst0 m_tvalid"}, 32'(g_inst[0].vld), 32'd0);
    chk({tag, " inst0 s_tready"}, 32'(g_inst[0].rdy), 32'd1);
    chk({tag, " inst1 count"}, 32'(g_inst[1].cnt), 32'd0);
    chk({tag, " inst1 m_tvalid"}, 32'(g_inst[1].vld), 32'd0);
    chk({tag, " inst1 s_tready"}, 32'(g_inst[1].rdy), 32'd1);
    chk({tag, " inst2 count"}, 32'(g_inst[2].cnt), 32'd0);
    chk({tag, " inst2 m_tvalid"}, 32'(g_inst[2].vld), 32'd0);
    chk({tag, " inst2 s_tready"}, 32'(g_inst[2].rdy), 32'd1);
  endtask

  initial begin
    // Fill DEPTH-4 buffer with m_tready low, then drain; expectations are for instance 0.
    tbl[0] = '{1'b1, 8'hA1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0};
    tbl[1] = '{1'b1, 8'hA2, 1'b0, 1'b1, 1'b1, 8'hA1, 3'd1};
    tbl[2] = '{1'b1, 8'hA3, 1'b0, 1'b1, 1'b1, 8'hA1, 3'd2};
    tbl[3] = '{1'b1, 8'hA4, 1'b0, 1'b1, 1'b1, 8'hA1, 3'd3};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA1, 3'd4};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA2, 3'd3};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA3, 3'd2};
    tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA4, 3'd1};
    tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0};

    #2;
    check_idle("reset");
    chk("reset inst0 m_tdata", 32'(g_inst[0].dat), 32'd0);
    chk("reset inst1 m_tdata", 32'(g_inst[1].dat), 32'd0);
    #10 rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].sv, tbl[i].d, tbl[i].mr, 1'b0);
      #3;
      chk($sformatf("fill row%0d count", i), 32'(g_inst[0].cnt), 32'(tbl[i].e_cnt));
      chk($sformatf("fill row%0d s_tready", i), 32'(g_inst[0].rdy), 32'(tbl[i].e_rdy));
      chk($sformatf("fill row%0d m_tvalid", i), 32'(g_inst[0].vld), 32'(tbl[i].e_vld));
      if (tbl[i].e_vld)
        chk($sformatf("fill row%0d m_tdata", i), 32'(g_inst[0].dat), 32'(tbl[i].e_dat));
    end

    // Continuous stream through the DEPTH-2 registered buffer.
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, W'(i), 1'b1, 1'b0);
      #3;
      if (i > 1) begin
        chk($sformatf("stream%0d count", i), 32'(g_inst[1].cnt), 32'd1);
        chk($sformatf("stream%0d m_tdata", i), 32'(g_inst[1].dat), 32'(i - 1));
      end
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    #3 chk("stream tail m_tdata", 32'(g_inst[1].dat), 32'd10);
    drive(1'b0, 8'h00, 1'b0, 1'b0);

    // FULL with m_tready high: pop only, refill the next cycle.
    drive(1'b1, 8'hB1, 1'b0, 1'b0);
    drive(1'b1, 8'hB2, 1'b0, 1'b0);
    drive(1'b1, 8'hB3, 1'b1, 1'b0);
    #3;
    chk("full s_tready", 32'(g_inst[1].rdy), 32'd0);
    chk("full m_tdata", 32'(g_inst[1].dat), 32'hB1);
    chk("full count", 32'(g_inst[1].cnt), 32'd2);
    drive(1'b1, 8'hB3, 1'b1, 1'b0);
    #3;
    chk("refill s_tready", 32'(g_inst[1].rdy), 32'd1);
    chk("refill m_tdata", 32'(g_inst[1].dat), 32'hB2);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    #3 chk("refill tail m_tdata", 32'(g_inst[1].dat), 32'hB3);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #3 chk("refill drained m_tvalid", 32'(g_inst[1].vld), 32'd0);

    // Flush (two cycles) while holding three entries in instance 0.
    drive(1'b1, 8'hC1, 1'b0, 1'b0);
    drive(1'b1, 8'hC2, 1'b0, 1'b0);
    drive(1'b1, 8'hC3, 1'b0, 1'b0);
    drive(1'b1, 8'hC0, 1'b1, 1'b1);
    #3;
    chk("flush s_tready", 32'(g_inst[0].rdy), 32'd0);
    chk("flush m_tvalid", 32'(g_inst[0].vld), 32'd0);
    drive(1'b1, 8'hC0, 1'b1, 1'b1);
    #3 chk("flush2 count", 32'(g_inst[0].cnt), 32'd0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    #3 check_idle("post-flush");
    drive(1'b0, 8'h00, 1'b1, 1'b0);

    // Fall-through instance, empty.
    drive(1'b1, 8'hD5, 1'b1, 1'b0);
    #3;
    chk("ft m_tvalid", 32'(g_inst[2].vld), 32'd1);
    chk("ft m_tdata", 32'(g_inst[2].dat), 32'hD5);
    chk("ft count", 32'(g_inst[2].cnt), 32'd0);
    drive(1'b1, 8'hD5, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #3;
    chk("ft stored count", 32'(g_inst[2].cnt), 32'd1);
    chk("ft stored m_tdata", 32'(g_inst[2].dat), 32'hD5);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);

    // Asynchronous reset pulse between clock edges with two entries held.
    drive(1'b1, 8'hE1, 1'b0, 1'b0);
    drive(1'b1, 8'hE2, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #3 chk("pre-rst inst0 count", 32'(g_inst[0].cnt), 32'd2);
    rst = 1'b1;
    #1 check_idle("async rst");
    #1 rst = 1'b0;
    drive(1'b1, 8'hF1, 1'b0, 1'b0);
    #3 chk("post-rst s_tready", 32'(g_inst[0].rdy), 32'd1);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    #3;
    chk("post-rst m_tdata", 32'(g_inst[0].dat), 32'hF1);
    chk("post-rst count", 32'(g_inst[0].cnt), 32'd1);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/offnariscv_stage_fifo.md
# offnariscv_stage_fifo

Parametrised, flushable elastic buffer between offnariscv pipeline stages (IF→ID, ID→RF, RF→EX, EX→WB). It carries any stage tdata struct as a flat vector over a valid/ready handshake, holds up to DEPTH entries, and discards all contents in one cycle on a pipeline flush (branch redirect, trap). It replaces the single-entry stage registers and adds depth, occupancy reporting and an optional same-cycle fall-through mode.

## Interface
- TDATA_WIDTH, 32: width of s_tdata/m_tdata; instantiated with $bits of the stage struct (e.g. idrf_tdata_t).
- DEPTH, 2: number of entries; power of two, ≥2.
- FALL_THROUGH, 0: 0 = registered output, minimum latency 1 cycle; 1 = empty buffer forwards input to output in the same cycle.
- CNT_WIDTH, $clog2(DEPTH+1): derived, not overridden.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous discard of all entries and of any in-flight handshake.
- s_tvalid  in  1  upstream data valid.
- s_tready  out  1  buffer can accept.
- s_tdata  in  TDATA_WIDTH  upstream payload.
- m_tvalid  out  1  head entry valid.
- m_tready  in  1  downstream accepts.
- m_tdata  out  TDATA_WIDTH  head payload.
- count  out  CNT_WIDTH  current occupancy, 0..DEPTH.

## Operation
- Storage: DEPTH-entry array, read pointer rp and write pointer wp of $clog2(DEPTH) bits, wrapping modulo DEPTH; occupancy counter cnt of CNT_WIDTH bits.
- States: EMPTY (cnt=0), PARTIAL (0<cnt<DEPTH), FULL (cnt=DEPTH), derived from cnt.
- Push = s_tvalid & s_tready & !flush; pop = m_tvalid & m_tready & !flush.
- s_tready = !FULL & !flush. Depends only on registered state and flush; no path from m_tready.
- FALL_THROUGH=0: m_tvalid = !EMPTY & !flush; m_tdata = mem[rp].
- FALL_THROUGH=1: when EMPTY, m_tvalid = s_tvalid & !flush and m_tdata = s_tdata; a push popped in the same cycle is not written and cnt stays 0. When not EMPTY, behaves as mode 0.
- Push writes mem[wp], wp+1. Pop advances rp+1. cnt += push − pop; simultaneous push and pop leave cnt unchanged in PARTIAL.
- FULL with m_tready=1: pop only; s_tready=0 that cycle (no same-cycle refill), FULL→PARTIAL.
- flush: next edge rp=wp=cnt=0; every transfer presented in the flush cycle is dropped on both sides; payload array is not cleared.
- count = cnt (fall-through transfers never counted).
- Upstream must hold s_tdata stable while s_tvalid & !s_tready; the buffer holds m_tdata stable while m_tvalid & !m_tready.

## Timing
- Reset values (asynchronous, while rst=1): rp=wp=0, cnt=0, count=0, m_tvalid=0, s_tready=1, m_tdata=0 in mode 0 (mem[0] reset to 0; other entries unreset).
- Latency: mode 0, push at edge N → m_tvalid=1 in cycle N+1. Mode 1, empty: 0 cycles.
- Throughput: 1 transfer/cycle in EMPTY (mode 1) and PARTIAL; in FULL only pops.
- rst asserted mid-transfer: all contents lost immediately; first handshake possible in the first cycle after deassertion.
- flush with rst: rst dominates. flush for several cycles: buffer stays EMPTY, s_tready=0, m_tvalid=0 throughout.
- Wrap-around: pointers wrap DEPTH−1→0 without a gap; FIFO order preserved across wrap.

## Test plan
- DEPTH=4, mode 0: push 0xA1..0xA4 with m_tready=0 → count 1,2,3,4, s_tready=0 after 4th; then m_tready=1 → pops A1,A2,A3,A4 in order, count 3..0, m_tvalid=0 afterwards.
- Continuous stream of 10 words, s_tvalid=m_tready=1, DEPTH=2 → pointers wrap ≥4 times, output order 1..10, count steady at 1, one transfer per cycle after first.
- FULL (DEPTH=2, 0xB1,0xB2), m_tready=1 and s_tvalid=1 with 0xB3 → B1 popped, B3 not accepted that cycle, accepted next cycle; order B1,B2,B3.
- Holding 3 entries, flush=1 with s_tvalid=1 (0xC0) and m_tready=1 → no handshake; next cycle count=0, m_tvalid=0, s_tready=1; 0xC0 never emitted.
- Mode 1, empty, s_tvalid=1 0xD5, m_tready=1 → m_tvalid=1, m_tdata=0xD5 same cycle, count stays 0; with m_tready=0 → 0xD5 stored, count=1 next cycle.
- rst pulsed asynchronously mid-cycle with 2 entries → m_tvalid=0, count=0, s_tready=1 immediately, before the next clock edge.
